// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin grant arbiter.
//   ST_IDLE / ST_BUSY : FSM state encodings
//   arb_state_e       : typed FSM state built on those encodings
//   next_idx()        : requester index increment with wrap (n-1 -> 0)
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StBusy = ST_BUSY
    } arb_state_e;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter_if
// Request/grant bundle between the requesters and the arbiter.
//   req       : request vector, bit k = requester k
//   gnt       : one-hot grant, zero when idle
//   gnt_idx   : binary index of the owner, 0 when idle
//   gnt_valid : high while any grant is held
//   timeout   : one-cycle pulse on a forced revoke
// Modports: slave = arbiter side, master = requester side.
// ---------------------------------------------------------------------------
interface rr_grant_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) ();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

endinterface

// File: rtl/rr_prio_encoder.sv
// ---------------------------------------------------------------------------
// rr_prio_encoder
// Combinational rotating priority encoder. The search starts one past
// i_last_idx and wraps, so the previous winner has the lowest priority.
//   i_req       : request vector
//   i_last_idx  : index of the previous winner
//   o_win_idx   : index of the first set request found (0 if none)
//   o_win_valid : high when any request is set
// ---------------------------------------------------------------------------
module rr_prio_encoder
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_idx,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_win_valid
);

    always_comb begin
        int unsigned w_cand;
        logic [IDX_W-1:0] w_cand_idx;
        o_win_idx   = '0;
        o_win_valid = 1'b0;
        w_cand      = 32'(i_last_idx);
        w_cand_idx  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_cand     = next_idx(w_cand, N_REQ);
            w_cand_idx = IDX_W'(w_cand);
            // First hit wins; later candidates have lower priority.
            if (!o_win_valid && i_req[w_cand_idx]) begin
                o_win_valid = 1'b1;
                o_win_idx   = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter
// Round-robin arbiter sharing one resource among N_REQ requesters. A grant
// is held until its owner drops the request; on release the grant moves to
// the next winner at the same edge. All outputs are registered.
//   clk     : clock, all state updates on posedge
//   rst_n   : asynchronous active-low reset
//   arb_bus : rr_grant_arbiter_if.slave (req in; gnt, gnt_idx, gnt_valid,
//             timeout out)
// Optional feature: define TIMEOUT_EN to revoke a grant held for MAX_HOLD
// cycles and pulse timeout. Without it, timeout is tied to 0.
// ---------------------------------------------------------------------------
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic               clk,
    input logic               rst_n,
    rr_grant_arbiter_if.slave arb_bus
);

    if (N_REQ < 2 || IDX_W != $clog2(N_REQ) || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_grant_arbiter: invalid parameter combination");
    end

    arb_state_e       r_state;
    arb_state_e       w_state_d;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_d;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_d;
    logic             r_gnt_valid;
    logic             w_gnt_valid_d;
    logic [IDX_W-1:0] r_last_idx;
    logic [IDX_W-1:0] w_last_idx_d;

    logic             w_owner_req;
    logic             w_revoke;
    logic [N_REQ-1:0] w_enc_req;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_valid;

    assign w_owner_req = arb_bus.req[r_gnt_idx];

`ifdef TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_d;
    logic              r_timeout;
    logic [N_REQ-1:0]  w_owner_bit;

    assign w_owner_bit = N_REQ'(1) << r_gnt_idx;
    assign w_revoke    = (r_state == StBusy) && w_owner_req &&
                         (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
    // Hide the revoked owner so it cannot immediately win again.
    assign w_enc_req   = w_revoke ? (arb_bus.req & ~w_owner_bit) : arb_bus.req;
    // Count only while the same owner keeps the grant.
    assign w_hold_cnt_d = (r_state == StBusy && w_owner_req && !w_revoke) ?
                          r_hold_cnt + HOLD_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_d;
            r_timeout  <= w_revoke;
        end
    end

    assign arb_bus.timeout = r_timeout;
`else
    assign w_revoke        = 1'b0;
    assign w_enc_req       = arb_bus.req;
    assign arb_bus.timeout = 1'b0;
`endif

    rr_prio_encoder #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_prio_encoder (
        .i_req       (w_enc_req),
        .i_last_idx  (r_last_idx),
        .o_win_idx   (w_win_idx),
        .o_win_valid (w_win_valid)
    );

    always_comb begin
        w_state_d     = r_state;
        w_gnt_idx_d   = r_gnt_idx;
        w_gnt_valid_d = r_gnt_valid;
        w_last_idx_d  = r_last_idx;
        unique case (r_state)
            StIdle: begin
                if (w_win_valid) begin
                    w_state_d     = StBusy;
                    w_gnt_idx_d   = w_win_idx;
                    w_gnt_valid_d = 1'b1;
                    w_last_idx_d  = w_win_idx;
                end
            end
            StBusy: begin
                if (!w_owner_req || w_revoke) begin
                    if (w_win_valid) begin
                        w_gnt_idx_d  = w_win_idx;
                        w_last_idx_d = w_win_idx;
                    end else begin
                        // last_idx keeps the old owner so it stays lowest priority.
                        w_state_d     = StIdle;
                        w_gnt_idx_d   = '0;
                        w_gnt_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                w_state_d     = StIdle;
                w_gnt_idx_d   = '0;
                w_gnt_valid_d = 1'b0;
            end
        endcase
        w_gnt_d = w_gnt_valid_d ? (N_REQ'(1) << w_gnt_idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_last_idx  <= IDX_W'(N_REQ - 1);
        end else begin
            r_state     <= w_state_d;
            r_gnt       <= w_gnt_d;
            r_gnt_idx   <= w_gnt_idx_d;
            r_gnt_valid <= w_gnt_valid_d;
            r_last_idx  <= w_last_idx_d;
        end
    end

    assign arb_bus.gnt       = r_gnt;
    assign arb_bus.gnt_idx   = r_gnt_idx;
    assign arb_bus.gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_arbiter
// Self-checking bench for rr_grant_arbiter: directed scenarios followed by
// randomized requests, compared against a behavioural owner/last-winner model.
// Define TIMEOUT_EN to also cover the forced-revoke feature.
// ---------------------------------------------------------------------------
module tb_rr_grant_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_grant_arbiter_if #(.N_REQ(N), .IDX_W(IW)) bus ();

    rr_grant_arbiter #(
        .N_REQ    (N),
        .IDX_W    (IW),
        .MAX_HOLD (MH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current owner (-1 = idle), last winner, cycles held.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_pick(input logic [N-1:0] r);
        m_owner = -1;
        m_hold  = 0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (r[c]) begin
                m_owner = c;
                m_last  = c;
                break;
            end
        end
    endtask

    task automatic model_step(input logic [N-1:0] r_in);
        logic [N-1:0] r;
        r    = r_in;
        m_to = 1'b0;
        if (m_owner >= 0 && r[m_owner]) begin
`ifdef TIMEOUT_EN
            if (m_hold == MH - 1) begin
                m_to       = 1'b1;
                r[m_owner] = 1'b0;
                model_pick(r);
                return;
            end
`endif
            m_hold++;
            return;
        end
        model_pick(r);
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0]  e_gnt;
        logic [IW-1:0] e_idx;
        e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_idx = (m_owner >= 0) ? IW'(m_owner) : '0;
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(e_gnt));
        chk({tag, ".gnt_idx"}, 32'(bus.gnt_idx), 32'(e_idx));
        chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(m_owner >= 0));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(m_to));
    endtask

    // Advance one edge, update the model with the req seen at that edge, check.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_step(bus.req);
        check_all(tag);
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;

        // Reset held with every requester active.
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.gnt_const", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;

        // Single requester, grant then release.
        bus.req = 4'b0100;
        tick("single_gnt");
        chk("single_gnt_const", 32'(bus.gnt), 32'h4);
        chk("single_idx_const", 32'(bus.gnt_idx), 32'd2);
        bus.req = 4'b0000;
        tick("single_rel");
        chk("single_rel_valid", 32'(bus.gnt_valid), 32'd0);

        // Rotation: everyone requests, owner drops for one edge after holding.
        do_reset("rot_rst");
        bus.req = 4'b1111;
        tick("rot_first");
        chk("rot_first_idx", 32'(bus.gnt_idx), 32'd0);
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 4;
            tick("rot_hold");
            chk("rot_hold_idx", 32'(bus.gnt_idx), 32'(e));
            r       = 4'b1111;
            r[e]    = 1'b0;
            bus.req = r;
            tick("rot_move");
            chk("rot_move_idx", 32'(bus.gnt_idx), 32'((e + 1) % 4));
            chk("rot_move_valid", 32'(bus.gnt_valid), 32'd1);
            bus.req = 4'b1111;
        end

        // Hold: owner 1 keeps the grant while req[3] toggles.
        do_reset("hold_rst");
        bus.req = 4'b0010;
        tick("hold_gnt");
        for (int k = 0; k < 6; k++) begin
            bus.req = (k % 2 == 0) ? 4'b1010 : 4'b0010;
            tick("hold_toggle");
            chk("hold_gnt_const", 32'(bus.gnt), 32'h2);
        end
        bus.req = 4'b1000;
        tick("hold_release");
        chk("hold_release_const", 32'(bus.gnt), 32'h8);

        // Async reset mid-grant, then priority of req[0] side restored.
        do_reset("mid_rst");
        chk("mid_rst_gnt_const", 32'(bus.gnt), 32'h0);
        bus.req = 4'b1010;
        tick("post_rst");
        chk("post_rst_const", 32'(bus.gnt), 32'h2);

`ifdef TIMEOUT_EN
        // Two requesters held: grant alternates every MAX_HOLD cycles.
        do_reset("to_rst");
        bus.req = 4'b0011;
        tick("to_first");
        for (int k = 0; k < MH - 1; k++) tick("to_hold0");
        tick("to_revoke0");
        chk("to_pulse0", 32'(bus.timeout), 32'd1);
        chk("to_gnt1", 32'(bus.gnt), 32'h2);
        for (int k = 0; k < MH - 1; k++) tick("to_hold1");
        tick("to_revoke1");
        chk("to_pulse1", 32'(bus.timeout), 32'd1);
        chk("to_gnt0", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0100;
        for (int k = 0; k < MH + 2; k++) tick("to_single");
        bus.req = 4'b0000;
        tick("to_idle");
`endif

        // Randomized: sticky requests with occasional flips and resets.
        do_reset("rand_rst");
        r = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            bus.req = r;
            if ($urandom_range(0, 79) == 0) begin
                do_reset("rand_async_rst");
            end else begin
                tick("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the directed sequence is short; never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
